// File: rtl/pll_reset_sequencer_if.sv
// Status and control bundle between the PLL reset sequencer and its surroundings:
// the PLL lock input plus all reset/status outputs of the sequencer.
interface pll_reset_sequencer_if #(
    parameter int RETRY_WIDTH = 8
);
    logic                   locked_in;
    logic                   pll_rst;
    logic                   sys_rst;
    logic                   ready;
    logic                   lock_fail;
    logic [RETRY_WIDTH-1:0] relock_count;
    logic [1:0]             state;

    modport master (
        input  locked_in,
        output pll_rst, sys_rst, ready, lock_fail, relock_count, state
    );

    modport slave (
        output locked_in,
        input  pll_rst, sys_rst, ready, lock_fail, relock_count, state
    );
endinterface

// File: rtl/pll_reset_sequencer.sv
// Brings the PLL out of reset on the free-running reference clock and releases the
// downstream system reset only after the lock has been stable for a full window.
module pll_reset_sequencer #(
    parameter int RST_PULSE_CYCLES    = 16,
    parameter int LOCK_TIMEOUT_CYCLES = 50000,
    parameter int STABLE_CYCLES       = 1024,
    parameter int CNT_WIDTH           = 20,
    parameter int RETRY_WIDTH         = 8
) (
    input  logic                   refclk,
    input  logic                   rst,
    pll_reset_sequencer_if.master  bus
);

    typedef enum logic [1:0] {
        PLL_RST   = 2'd0,
        WAIT_LOCK = 2'd1,
        STABILIZE = 2'd2,
        RUN       = 2'd3
    } state_t;

    localparam logic [CNT_WIDTH-1:0]   RST_LAST     = CNT_WIDTH'(RST_PULSE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0]   TIMEOUT_LAST = CNT_WIDTH'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0]   STABLE_LAST  = CNT_WIDTH'(STABLE_CYCLES - 1);
    localparam logic [RETRY_WIDTH-1:0] RELOCK_MAX   = '1;

    state_t                 cur_state;
    state_t                 next_state;
    logic [CNT_WIDTH-1:0]   counter;
    logic [CNT_WIDTH-1:0]   counter_next;
    logic                   sync_meta;
    logic                   locked_s;
    logic                   pll_rst_q;
    logic                   sys_rst_q;
    logic                   ready_q;
    logic                   lock_fail_q;
    logic                   lock_fail_next;
    logic [RETRY_WIDTH-1:0] relock_q;
    logic [RETRY_WIDTH-1:0] relock_next;

    // locked_in comes from the PLL with no relation to refclk
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            sync_meta <= 1'b0;
            locked_s  <= 1'b0;
        end else begin
            sync_meta <= bus.locked_in;
            locked_s  <= sync_meta;
        end
    end

    always_comb begin
        next_state     = cur_state;
        counter_next   = counter + 1'b1;
        lock_fail_next = lock_fail_q;
        relock_next    = relock_q;
        case (cur_state)
            PLL_RST: begin
                if (counter == RST_LAST) begin
                    next_state   = WAIT_LOCK;
                    counter_next = '0;
                end
            end
            WAIT_LOCK: begin
                if (locked_s) begin
                    next_state   = STABILIZE;
                    counter_next = '0;
                end else if (counter == TIMEOUT_LAST) begin
                    next_state     = PLL_RST;
                    counter_next   = '0;
                    lock_fail_next = 1'b1;
                end
            end
            STABILIZE: begin
                if (!locked_s) begin
                    next_state   = WAIT_LOCK;
                    counter_next = '0;
                end else if (counter == STABLE_LAST) begin
                    next_state   = RUN;
                    counter_next = '0;
                end
            end
            RUN: begin
                counter_next = counter;
                if (!locked_s) begin
                    next_state   = WAIT_LOCK;
                    counter_next = '0;
                    if (relock_q != RELOCK_MAX) begin
                        relock_next = relock_q + 1'b1;
                    end
                end
            end
            default: begin
                next_state   = PLL_RST;
                counter_next = '0;
            end
        endcase
    end

    // Outputs are decoded from the state being entered so they move on the transition edge
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            cur_state   <= PLL_RST;
            counter     <= '0;
            pll_rst_q   <= 1'b1;
            sys_rst_q   <= 1'b1;
            ready_q     <= 1'b0;
            lock_fail_q <= 1'b0;
            relock_q    <= '0;
        end else begin
            cur_state   <= next_state;
            counter     <= counter_next;
            pll_rst_q   <= (next_state == PLL_RST);
            sys_rst_q   <= (next_state != RUN);
            ready_q     <= (next_state == RUN);
            lock_fail_q <= lock_fail_next;
            relock_q    <= relock_next;
        end
    end

    assign bus.pll_rst      = pll_rst_q;
    assign bus.sys_rst      = sys_rst_q;
    assign bus.ready        = ready_q;
    assign bus.lock_fail    = lock_fail_q;
    assign bus.relock_count = relock_q;
    assign bus.state        = cur_state;

endmodule
